// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared FSM state type and width helpers for the BCD divider datapath.
package mul_div_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DIV, DONE} state_t;
    localparam int N_DEF = 8;
    localparam int CNT_W = $clog2(2*N_DEF+1);
    function automatic int bcd_width(input int n);
        return ((2*n)/3+1)*4;
    endfunction
endpackage

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: reverse double-dabble engine, one bit of binary per step.
// residue_nz reflects the BCD residue produced by the step in progress.
module bcd_to_bin_seq import mul_div_pkg::*; #(
    parameter int N     = 8,
    parameter int BCD_W = bcd_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [BCD_W-1:0] bcd_in,
    output logic [2*N-1:0]   bin_out,
    output logic             residue_nz
);
    logic [BCD_W-1:0] bcd_reg, bcd_nxt;
    logic [2*N-1:0]   bin_nxt;
    always_comb begin
        bin_nxt = {bcd_reg[0], bin_out[2*N-1:1]};
        bcd_nxt = bcd_reg >> 1;
        for (int i = 0; i < BCD_W/4; i++)
            bcd_nxt[4*i+:4] = (bcd_nxt[4*i+:4] >= 4'd8) ? bcd_nxt[4*i+:4] - 4'd3 : bcd_nxt[4*i+:4];
    end
    assign residue_nz = |bcd_nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_reg <= '0;
            bin_out <= '0;
        end else if (load) begin
            bcd_reg <= bcd_in;
            bin_out <= '0;
        end else if (step) begin
            bcd_reg <= bcd_nxt;
            bin_out <= bin_nxt;
        end
    end
endmodule

// File: rtl/bcd_divider.sv
// bcd_divider: packed-BCD dividend / binary divisor via BCD->binary conversion then restoring division.
// Optional BCD_DIGIT_CHECK_EN adds err_digit and rejects nibbles above 9 on the start cycle.
module bcd_divider import mul_div_pkg::*; #(
    parameter int N     = 8,
    parameter int BCD_W = bcd_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             err_div0,
    output logic             err_ovf
`ifdef BCD_DIGIT_CHECK_EN
    , output logic           err_digit
`endif
);
    localparam int DW = 2*N;
    localparam int CW = $clog2(DW+1);
    localparam int IW = $clog2(DW);
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    div_reg, rem;
    logic [DW-1:0]   q, bin;
    logic            residue_nz, last, sub_ok, fail;
    logic [IW-1:0]   idx;
    logic [N:0]      t;
    bcd_to_bin_seq #(.N(N), .BCD_W(BCD_W)) u_conv (
        .clk(clk), .reset(reset),
        .load(state == IDLE && start), .step(state == CONV),
        .bcd_in(bcd_in), .bin_out(bin), .residue_nz(residue_nz)
    );
    // The converted dividend is read in place, MSB first, instead of being copied.
    assign idx    = IW'(DW-1) - IW'(cnt);
    assign t      = {rem, bin[idx]};
    assign sub_ok = t >= {1'b0, div_reg};
    assign last   = cnt == CW'(DW-1);
`ifdef BCD_DIGIT_CHECK_EN
    logic bad_digit;
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < BCD_W/4; i++) bad_digit = bad_digit | (bcd_in[4*i+:4] > 4'd9);
    end
    assign fail = err_ovf | err_div0 | err_digit;
`else
    assign fail = err_ovf | err_div0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div_reg   <= '0;
            rem       <= '0;
            q         <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_div0  <= 1'b0;
            err_ovf   <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_digit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    div_reg  <= divisor;
                    cnt      <= '0;
                    rem      <= '0;
                    q        <= '0;
                    err_div0 <= 1'b0;
                    err_ovf  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                    err_digit <= bad_digit;
                    busy      <= !bad_digit;
                    state     <= bad_digit ? DONE : CONV;
`else
                    busy  <= 1'b1;
                    state <= CONV;
`endif
                end
                CONV: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        err_ovf  <= residue_nz;
                        err_div0 <= !residue_nz && div_reg == '0;
                        busy     <= !residue_nz && div_reg != '0;
                        state    <= (residue_nz || div_reg == '0) ? DONE : DIV;
                    end
                end
                DIV: begin
                    rem   <= N'(sub_ok ? t - {1'b0, div_reg} : t);
                    q     <= {q[DW-2:0], sub_ok};
                    cnt   <= last ? '0 : cnt + 1'b1;
                    busy  <= !last;
                    state <= last ? DONE : DIV;
                end
                DONE: begin
                    quotient  <= fail ? '1 : q;
                    remainder <= fail ? '0 : rem;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
